// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock's time-setting path.
//   - field widths for year/month/day/hour/minute/second
//   - field_t: edit FSM state, which doubles as the display blink-field code
//   - reset date constants
//   - is_leap / days_in_month calendar helpers
package clock_pkg;

    localparam int YEAR_W  = 16;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    // Encoding is visible on edit_field, so the values are fixed.
    typedef enum logic [2:0] {
        F_IDLE   = 3'd0,
        F_YEAR   = 3'd1,
        F_MONTH  = 3'd2,
        F_DAY    = 3'd3,
        F_HOUR   = 3'd4,
        F_MINUTE = 3'd5,
        F_SECOND = 3'd6
    } field_t;

    localparam int                 RST_YEAR  = 2000;
    localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
    localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;

    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return ((year % 16'd400) == 16'd0) ||
               (((year % 16'd4) == 16'd0) && ((year % 16'd100) != 16'd0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic [YEAR_W-1:0]  year);
        case (month)
            4'd2:                     return is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                  return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus tick-sampled debouncer for one button.
//   clk, rst   system clock, asynchronous active-high reset
//   tick_ms    1 kHz sampling strobe
//   btn_raw    raw asynchronous button level
//   level      debounced level
//   press      one-cycle pulse on a debounced 0->1 transition
module button_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync_p0, sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (tick_ms) begin
                // Count consecutive samples disagreeing with the accepted level;
                // any agreeing sample restarts the run.
                if (sync_p1 != level) begin
                    if (cnt == CNT_LAST) begin
                        level <= sync_p1;
                        press <= sync_p1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/time_editor.sv
// time_editor: user time-setting front end.
//   clk, rst                       system clock, asynchronous active-high reset
//   tick_ms                        1 kHz strobe (debounce sampling, edit timeout)
//   up/down/left/right/middle      raw buttons
//   cur_*                          live time, snapshotted when an edit starts
//   set_*                          edited date/time (registered)
//   set_load                       one-cycle commit strobe
//   edit_active, edit_field        edit status / field being edited (0 = idle)
module time_editor
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_MS  = 10000,
    parameter int YEAR_MIN    = RST_YEAR,
    parameter int YEAR_MAX    = 2099
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        middle,
    input  logic [15:0] cur_year,
    input  logic [3:0]  cur_month,
    input  logic [4:0]  cur_day,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_minute,
    input  logic [5:0]  cur_second,
    output logic [15:0] set_year,
    output logic [3:0]  set_month,
    output logic [4:0]  set_day,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_minute,
    output logic [5:0]  set_second,
    output logic        set_load,
    output logic        edit_active,
    output logic [2:0]  edit_field
);

    localparam logic [YEAR_W-1:0] YMIN    = 16'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX    = 16'(YEAR_MAX);
    localparam int                TO_W    = $clog2(TIMEOUT_MS + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_MS - 1);

    field_t            state, state_n;
    logic [4:0]        prs;
    logic [4:0]        btn_level_unused;   // only press edges drive the editor
    logic              p_mid, p_left, p_right, p_up, p_dn, any_press, edit;
    logic [TO_W-1:0]   to_cnt;
    logic [YEAR_W-1:0] n_year;
    logic [3:0]        n_month;
    logic [4:0]        n_day, n_hour, dim_cur, dim_new;
    logic [5:0]        n_minute, n_second;

    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mid (.clk(clk), .rst(rst), .tick_ms(tick_ms),
        .btn_raw(middle), .level(btn_level_unused[4]), .press(prs[4]));
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_left (.clk(clk), .rst(rst), .tick_ms(tick_ms),
        .btn_raw(left), .level(btn_level_unused[3]), .press(prs[3]));
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_right (.clk(clk), .rst(rst), .tick_ms(tick_ms),
        .btn_raw(right), .level(btn_level_unused[2]), .press(prs[2]));
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (.clk(clk), .rst(rst), .tick_ms(tick_ms),
        .btn_raw(up), .level(btn_level_unused[1]), .press(prs[1]));
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_down (.clk(clk), .rst(rst), .tick_ms(tick_ms),
        .btn_raw(down), .level(btn_level_unused[0]), .press(prs[0]));

    // Only the highest-priority press of a cycle survives.
    assign p_mid     = prs[4];
    assign p_left    = prs[3] & ~prs[4];
    assign p_right   = prs[2] & ~|prs[4:3];
    assign p_up      = prs[1] & ~|prs[4:2];
    assign p_dn      = prs[0] & ~|prs[4:1];
    assign any_press = |prs;
    assign edit      = (state != F_IDLE);

    assign edit_active = edit;
    assign edit_field  = state;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] lo,
                                        input logic [5:0] hi, input logic inc);
        if (inc) return (v >= hi) ? lo : v + 6'd1;
        else     return (v <= lo) ? hi : v - 6'd1;
    endfunction

    function automatic field_t next_field(input field_t f);
        case (f)
            F_YEAR:   return F_MONTH;
            F_MONTH:  return F_DAY;
            F_DAY:    return F_HOUR;
            F_HOUR:   return F_MINUTE;
            F_MINUTE: return F_SECOND;
            default:  return F_YEAR;
        endcase
    endfunction

    function automatic field_t prev_field(input field_t f);
        case (f)
            F_MONTH:  return F_YEAR;
            F_DAY:    return F_MONTH;
            F_HOUR:   return F_DAY;
            F_MINUTE: return F_HOUR;
            F_SECOND: return F_MINUTE;
            default:  return F_SECOND;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= F_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!edit) begin
            if (p_mid) state_n = F_HOUR;
        end else if (p_mid) begin
            state_n = F_IDLE;
        end else if (p_left) begin
            state_n = prev_field(state);
        end else if (p_right) begin
            state_n = next_field(state);
        end else if (!any_press && tick_ms && (to_cnt == TO_LAST)) begin
            state_n = F_IDLE;
        end
    end

    // Next edit-register values: snapshot on entry, field step while editing.
    always_comb begin
        n_year   = set_year;
        n_month  = set_month;
        n_day    = set_day;
        n_hour   = set_hour;
        n_minute = set_minute;
        n_second = set_second;
        dim_cur  = days_in_month(set_month, set_year);
        if (!edit) begin
            if (p_mid) begin
                if (cur_year < YMIN)      n_year = YMIN;
                else if (cur_year > YMAX) n_year = YMAX;
                else                      n_year = cur_year;
                if (cur_month == 4'd0)      n_month = 4'd1;
                else if (cur_month > 4'd12) n_month = 4'd12;
                else                        n_month = cur_month;
                n_day    = (cur_day == 5'd0) ? 5'd1 : cur_day;
                n_hour   = (cur_hour > 5'd23) ? 5'd23 : cur_hour;
                n_minute = (cur_minute > 6'd59) ? 6'd59 : cur_minute;
                n_second = (cur_second > 6'd59) ? 6'd59 : cur_second;
            end
        end else if (p_up || p_dn) begin
            case (state)
                F_YEAR: begin
                    if (p_up) n_year = (set_year >= YMAX) ? YMIN : set_year + 16'd1;
                    else      n_year = (set_year <= YMIN) ? YMAX : set_year - 16'd1;
                end
                F_MONTH:  n_month  = 4'(step(6'(set_month), 6'd1, 6'd12, p_up));
                F_DAY:    n_day    = 5'(step(6'(set_day), 6'd1, 6'(dim_cur), p_up));
                F_HOUR:   n_hour   = 5'(step(6'(set_hour), 6'd0, 6'd23, p_up));
                F_MINUTE: n_minute = step(set_minute, 6'd0, 6'd59, p_up);
                F_SECOND: n_second = step(set_second, 6'd0, 6'd59, p_up);
                default:  ;
            endcase
        end
        // Keeps the day legal after any year/month change or snapshot.
        dim_new = days_in_month(n_month, n_year);
        if (n_day > dim_new) n_day = dim_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_year   <= YMIN;
            set_month  <= RST_MONTH;
            set_day    <= RST_DAY;
            set_hour   <= '0;
            set_minute <= '0;
            set_second <= '0;
            set_load   <= 1'b0;
            to_cnt     <= '0;
        end else begin
            set_year   <= n_year;
            set_month  <= n_month;
            set_day    <= n_day;
            set_hour   <= n_hour;
            set_minute <= n_minute;
            set_second <= n_second;
            set_load   <= edit && p_mid;
            if (!edit || any_press) to_cnt <= '0;
            else if (tick_ms)       to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_time_editor.sv
module tb_time_editor;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_ms = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
    logic [15:0] cur_year = 16'd2000;
    logic [3:0]  cur_month = 4'd1;
    logic [4:0]  cur_day = 5'd1;
    logic [4:0]  cur_hour = 5'd0;
    logic [5:0]  cur_minute = 6'd0;
    logic [5:0]  cur_second = 6'd0;
    logic [15:0] set_year;
    logic [3:0]  set_month;
    logic [4:0]  set_day;
    logic [4:0]  set_hour;
    logic [5:0]  set_minute;
    logic [5:0]  set_second;
    logic        set_load;
    logic        edit_active;
    logic [2:0]  edit_field;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;
    logic [15:0] ld_year;
    logic [3:0]  ld_month;
    logic [4:0]  ld_day, ld_hour;
    logic [5:0]  ld_minute, ld_second;

    localparam logic [4:0] B_MID = 5'b10000, B_LEFT = 5'b01000, B_RIGHT = 5'b00100,
                           B_UP = 5'b00010, B_DOWN = 5'b00001;

    time_editor dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms),
        .up(up), .down(down), .left(left), .right(right), .middle(middle),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .set_load(set_load), .edit_active(edit_active), .edit_field(edit_field)
    );

    always #5 clk = ~clk;
    // 1 ms tick on every other clock cycle keeps the 10 s timeout short in cycles.
    always @(negedge clk) tick_ms = ~tick_ms;

    // Capture every commit and the values presented with it.
    always @(negedge clk) begin
        if (set_load === 1'b1) begin
            load_cnt = load_cnt + 1;
            ld_year = set_year; ld_month = set_month; ld_day = set_day;
            ld_hour = set_hour; ld_minute = set_minute; ld_second = set_second;
        end
    end

    task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
        cur_year = 16'(y); cur_month = 4'(mo); cur_day = 5'(d);
        cur_hour = 5'(h); cur_minute = 6'(mi); cur_second = 6'(s);
    endtask

    // Hold the buttons in mask long enough to debounce, then release and settle.
    task automatic press(input logic [4:0] m);
        @(negedge clk);
        {middle, left, right, up, down} = m;
        repeat (60) @(negedge clk);
        {middle, left, right, up, down} = 5'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (set_year !== 16'd2000) begin errors++; $display("FAIL reset_year: got %0d want 2000", set_year); end
        checks++; if (set_month !== 4'd1) begin errors++; $display("FAIL reset_month: got %0d want 1", set_month); end
        checks++; if (set_day !== 5'd1) begin errors++; $display("FAIL reset_day: got %0d want 1", set_day); end
        checks++; if (set_hour !== 5'd0) begin errors++; $display("FAIL reset_hour: got %0d want 0", set_hour); end
        checks++; if (set_minute !== 6'd0) begin errors++; $display("FAIL reset_minute: got %0d want 0", set_minute); end
        checks++; if (set_second !== 6'd0) begin errors++; $display("FAIL reset_second: got %0d want 0", set_second); end
        checks++; if (set_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b want 0", set_load); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", edit_active); end
        checks++; if (edit_field !== 3'd0) begin errors++; $display("FAIL reset_field: got %0d want 0", edit_field); end
    endtask

    task automatic test_commit;
        int l0;
        l0 = load_cnt;
        set_cur(2023, 12, 31, 23, 59, 58);
        press(B_MID);
        checks++; if (edit_field !== 3'd4) begin errors++; $display("FAIL commit_enter_field: got %0d want 4", edit_field); end
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL commit_enter_active: got %0b want 1", edit_active); end
        checks++; if (set_hour !== 5'd23) begin errors++; $display("FAIL commit_snapshot_hour: got %0d want 23", set_hour); end
        checks++; if (load_cnt !== l0) begin errors++; $display("FAIL commit_no_load_on_entry: got %0d want %0d", load_cnt, l0); end
        press(B_UP);
        checks++; if (set_hour !== 5'd0) begin errors++; $display("FAIL commit_hour_wrap: got %0d want 0", set_hour); end
        // Live time moving during the edit must not leak in.
        set_cur(2025, 5, 5, 5, 5, 5);
        press(B_MID);
        checks++; if (load_cnt !== l0 + 1) begin errors++; $display("FAIL commit_load_count: got %0d want %0d", load_cnt, l0 + 1); end
        checks++; if ({ld_year, ld_month, ld_day} !== {16'd2023, 4'd12, 5'd31})
            begin errors++; $display("FAIL commit_date: got %0d-%0d-%0d want 2023-12-31", ld_year, ld_month, ld_day); end
        checks++; if ({ld_hour, ld_minute, ld_second} !== {5'd0, 6'd59, 6'd58})
            begin errors++; $display("FAIL commit_time: got %0d:%0d:%0d want 0:59:58", ld_hour, ld_minute, ld_second); end
        checks++; if (edit_field !== 3'd0) begin errors++; $display("FAIL commit_idle_field: got %0d want 0", edit_field); end
        checks++; if (set_hour !== 5'd0) begin errors++; $display("FAIL commit_hold_hour: got %0d want 0", set_hour); end
    endtask

    task automatic test_glitch_press;
        int l0;
        set_cur(2023, 1, 1, 5, 0, 0);
        press(B_MID);
        @(negedge clk); up = 1'b1;
        repeat (6) @(negedge clk);
        up = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (set_hour !== 5'd5) begin errors++; $display("FAIL glitch_no_press: got %0d want 5", set_hour); end
        up = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (set_hour !== 5'd6) begin errors++; $display("FAIL hold_one_press: got %0d want 6", set_hour); end
        repeat (3940) @(negedge clk);
        checks++; if (set_hour !== 5'd6) begin errors++; $display("FAIL hold_no_repeat: got %0d want 6", set_hour); end
        up = 1'b0;
        repeat (60) @(negedge clk);
        l0 = load_cnt;
        press(B_MID);
        checks++; if (load_cnt !== l0 + 1 || ld_hour !== 5'd6)
            begin errors++; $display("FAIL glitch_commit: got loads %0d hour %0d want %0d hour 6", load_cnt - l0, ld_hour, 1); end
    endtask

    task automatic test_day_clamp;
        set_cur(2024, 3, 31, 12, 0, 0);
        press(B_MID);
        press(B_LEFT);
        press(B_LEFT);
        checks++; if (edit_field !== 3'd2) begin errors++; $display("FAIL clamp_field_month: got %0d want 2", edit_field); end
        press(B_DOWN);
        checks++; if (set_month !== 4'd2 || set_day !== 5'd29)
            begin errors++; $display("FAIL clamp_leap_feb: got %0d/%0d want 2/29", set_month, set_day); end
        press(B_LEFT);
        press(B_DOWN);
        checks++; if (set_year !== 16'd2023 || set_day !== 5'd28)
            begin errors++; $display("FAIL clamp_year_down: got %0d day %0d want 2023 day 28", set_year, set_day); end
        press(B_MID);
        checks++; if ({ld_year, ld_month, ld_day} !== {16'd2023, 4'd2, 5'd28})
            begin errors++; $display("FAIL clamp_commit: got %0d-%0d-%0d want 2023-2-28", ld_year, ld_month, ld_day); end
    endtask

    task automatic test_wrap;
        set_cur(2099, 12, 15, 10, 20, 0);
        press(B_MID);
        press(B_LEFT);
        press(B_LEFT);
        press(B_LEFT);
        checks++; if (edit_field !== 3'd1) begin errors++; $display("FAIL wrap_field_year: got %0d want 1", edit_field); end
        press(B_UP);
        checks++; if (set_year !== 16'd2000) begin errors++; $display("FAIL wrap_year: got %0d want 2000", set_year); end
        press(B_RIGHT);
        press(B_UP);
        checks++; if (set_month !== 4'd1) begin errors++; $display("FAIL wrap_month: got %0d want 1", set_month); end
        for (int i = 0; i < 4; i++) press(B_RIGHT);
        checks++; if (edit_field !== 3'd6) begin errors++; $display("FAIL wrap_field_second: got %0d want 6", edit_field); end
        press(B_DOWN);
        checks++; if (set_second !== 6'd59) begin errors++; $display("FAIL wrap_second: got %0d want 59", set_second); end
        press(B_RIGHT);
        checks++; if (edit_field !== 3'd1) begin errors++; $display("FAIL wrap_right_to_year: got %0d want 1", edit_field); end
        press(B_MID);
    endtask

    task automatic test_snapshot_clamp;
        set_cur(3000, 0, 0, 30, 60, 63);
        press(B_MID);
        checks++; if ({set_year, set_month, set_day} !== {16'd2099, 4'd1, 5'd1})
            begin errors++; $display("FAIL snap_hi_date: got %0d-%0d-%0d want 2099-1-1", set_year, set_month, set_day); end
        checks++; if ({set_hour, set_minute, set_second} !== {5'd23, 6'd59, 6'd59})
            begin errors++; $display("FAIL snap_hi_time: got %0d:%0d:%0d want 23:59:59", set_hour, set_minute, set_second); end
        press(B_MID);
        set_cur(1990, 2, 31, 1, 2, 3);
        press(B_MID);
        checks++; if ({set_year, set_month, set_day} !== {16'd2000, 4'd2, 5'd29})
            begin errors++; $display("FAIL snap_lo_date: got %0d-%0d-%0d want 2000-2-29", set_year, set_month, set_day); end
        press(B_MID);
    endtask

    task automatic test_priority;
        int l0;
        set_cur(2023, 1, 1, 5, 0, 0);
        press(B_MID);
        l0 = load_cnt;
        press(B_MID | B_UP);
        checks++; if (load_cnt !== l0 + 1) begin errors++; $display("FAIL prio_load: got %0d want %0d", load_cnt - l0, 1); end
        checks++; if (ld_hour !== 5'd5) begin errors++; $display("FAIL prio_no_up: got %0d want 5", ld_hour); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL prio_idle: got %0b want 0", edit_active); end
    endtask

    task automatic test_timeout;
        int l0;
        l0 = load_cnt;
        set_cur(2022, 6, 15, 8, 30, 45);
        press(B_MID);
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL to_enter: got %0b want 1", edit_active); end
        repeat (19800) @(negedge clk);
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL to_still_active: got %0b want 1", edit_active); end
        repeat (400) @(negedge clk);
        checks++; if (edit_active !== 1'b0 || edit_field !== 3'd0)
            begin errors++; $display("FAIL to_abort: got active %0b field %0d want 0 0", edit_active, edit_field); end
        checks++; if (load_cnt !== l0) begin errors++; $display("FAIL to_no_load: got %0d want %0d", load_cnt, l0); end
        checks++; if ({set_year, set_month, set_day} !== {16'd2022, 4'd6, 5'd15})
            begin errors++; $display("FAIL to_date_kept: got %0d-%0d-%0d want 2022-6-15", set_year, set_month, set_day); end
        checks++; if ({set_hour, set_minute, set_second} !== {5'd8, 6'd30, 6'd45})
            begin errors++; $display("FAIL to_time_kept: got %0d:%0d:%0d want 8:30:45", set_hour, set_minute, set_second); end
    endtask

    task automatic test_reset_mid_edit;
        int l0;
        l0 = load_cnt;
        set_cur(2030, 7, 4, 12, 34, 56);
        press(B_MID);
        press(B_RIGHT);
        checks++; if (edit_field !== 3'd5) begin errors++; $display("FAIL rst_mid_field: got %0d want 5", edit_field); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({set_year, set_month, set_day} !== {16'd2000, 4'd1, 5'd1})
            begin errors++; $display("FAIL rst_mid_date: got %0d-%0d-%0d want 2000-1-1", set_year, set_month, set_day); end
        checks++; if ({set_hour, set_minute, set_second} !== {5'd0, 6'd0, 6'd0})
            begin errors++; $display("FAIL rst_mid_time: got %0d:%0d:%0d want 0:0:0", set_hour, set_minute, set_second); end
        checks++; if (edit_active !== 1'b0 || edit_field !== 3'd0 || set_load !== 1'b0)
            begin errors++; $display("FAIL rst_mid_flags: got %0b %0d %0b want 0 0 0", edit_active, edit_field, set_load); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (load_cnt !== l0 || edit_active !== 1'b0)
            begin errors++; $display("FAIL rst_mid_no_load: got %0d active %0b want %0d 0", load_cnt, edit_active, l0); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_glitch_press();
        test_day_clamp();
        test_wrap();
        test_snapshot_clamp();
        test_priority();
        test_timeout();
        test_reset_mid_edit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
